pc_fetch_stage: RTL and testbench

//  Owns the architectural PC and the IF/ID pipeline register. Each cycle it presents pc_plus4 to the
//  PC-source mux, takes back the selected next PC (pc_src), and fetches the instruction at pc over a
//  req/ack instruction-memory handshake. Handles hazard-unit stalls, IF/ID flushes, and control-transfer

---
 rtl/pc_fetch_stage_pkg.sv | 15 +
 rtl/pc_fetch_stage_ifid.sv | 42 ++++
 rtl/pc_fetch_stage.sv | 127 ++++++++++++
 tb/tb_pc_fetch_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding
// and the default reset PC / bubble instruction.
package pc_fetch_stage_pkg;

  // Fetch FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    S_REQ  = 2'b00,  // request outstanding at pc
    S_DROP = 2'b01,  // finishing a fetch that a redirect has squashed
    S_HOLD = 2'b10   // fetched word parked while the pipeline is stalled
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_stage_ifid.sv
// IF/ID pipeline register: {instr, pc_plus4, valid}.
// Update priority: rst > flush > stall > load. When neither stalled nor
// loading, a bubble is written.
module ifid_pipe_reg
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc_plus4,
  output logic        q_valid
);

  // Pipeline register update with reset/flush/stall/load priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || flush) begin
      q_instr    <= NOP_INSTR;
      q_pc_plus4 <= 32'd0;
      q_valid    <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        q_instr    <= instr;
        q_pc_plus4 <= pc_plus4;
        q_valid    <= 1'b1;
      end else begin
        q_instr    <= NOP_INSTR;
        q_pc_plus4 <= 32'd0;
        q_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, the req/ack fetch
// handshake (with squash of in-flight fetches on redirect) and the IF/ID
// pipeline register.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_src,
  input  logic        redirect,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_n;
  logic [31:0]  tgt, tgt_n;    // redirect target waiting for the dropped fetch
  logic [31:0]  hold, hold_n;  // fetched word parked during a stall
  logic         ifid_load;
  logic [31:0]  ifid_instr_in;

  // Sequential PC; wraps naturally modulo 2^32.
  assign pc_plus4 = pc + 32'd4;

  // The PC only moves after a fetch completes, so in S_DROP pc is still the
  // squashed address and the bus address never changes while waiting.
  assign imem_addr = pc;
  assign imem_req  = !rst && (state == S_REQ || state == S_DROP);

  // Next-state, next-PC and IF/ID load decision.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    state_n       = state;
    pc_n          = pc;
    tgt_n         = tgt;
    hold_n        = hold;
    ifid_load     = 1'b0;
    ifid_instr_in = imem_rdata;

    unique case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_n = pc_src;                 // fetched word is on the wrong path
          end else if (stall) begin
            hold_n  = imem_rdata;
            state_n = S_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_n      = pc_src;
          end
        end else if (redirect) begin
          tgt_n   = pc_src;
          state_n = S_DROP;
        end
      end

      S_DROP: begin
        if (imem_ack) begin
          // A redirect arriving with the ack is the newest target.
          pc_n    = redirect ? pc_src : tgt;
          state_n = S_REQ;
        end else if (redirect) begin
          tgt_n = pc_src;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_n    = pc_src;
          state_n = S_REQ;
        end else if (!stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = hold;
          pc_n          = pc_src;
          state_n       = S_REQ;
        end
      end

      default: state_n = S_REQ;
    endcase
  end

  // State, PC and side registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      tgt   <= 32'd0;
      hold  <= 32'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tgt   <= tgt_n;
      hold  <= hold_n;
    end
  end

  ifid_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .load       (ifid_load),
    .instr      (ifid_instr_in),
    .pc_plus4   (pc_plus4),
    .q_instr    (ifid_instr),
    .q_pc_plus4 (ifid_pc_plus4),
    .q_valid    (ifid_valid)
  );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed windows push expected IF/ID contents
// into a queue; a monitor pops one entry each time IF/ID is freshly loaded.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_src;
  logic        redirect;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  logic        seq;      // 1: pc_src follows pc_plus4 (sequential mux path)
  logic [31:0] src_val;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  pc_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .redirect      (redirect),
    .stall         (stall),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
  );

  // Instruction memory contents: a fixed, address-dependent pattern.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign imem_rdata = word_at(imem_addr);
  assign pc_src     = seq ? pc_plus4 : src_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] p4);
    exp_q.push_back('{instr: word_at(a), pc_plus4: p4});
  endtask

  task automatic next_win();
    @(posedge clk);
    #1;
  endtask

  // Monitor: IF/ID is freshly loaded when the edge saw no rst/flush/stall
  // and valid is now high.
  logic fresh;
  always @(posedge clk) fresh = !rst && !flush && !stall;

  always @(negedge clk) begin
    if (fresh && ifid_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ifid_load", ifid_instr, NOP);
        check("unexpected_ifid_valid", 32'(ifid_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_pc_plus4", ifid_pc_plus4, e.pc_plus4);
      end
    end
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect = 1'b0; seq = 1'b1; src_val = 32'd0;

    // Reset with ack high: no request may be presented.
    next_win(); next_win();
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_instr", ifid_instr, NOP);

    // T1: zero-wait sequential stream.
    next_win();                       // W0
    rst = 1'b0;
    push(32'h3000, 32'h3004);
    push(32'h3004, 32'h3008);
    push(32'h3008, 32'h300C);
    @(negedge clk);
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'h3000);
    next_win();                       // W1
    @(negedge clk);
    check("t1_valid", 32'(ifid_valid), 32'd1);
    check("t1_pc", pc, 32'h3004);
    next_win(); next_win();           // W3: pc = 0x300C

    // T2: stall on ack, held three cycles.
    stall = 1'b1;
    next_win();                       // W4
    @(negedge clk);
    check("t2_hold_req", 32'(imem_req), 32'd0);
    check("t2_hold_pc", pc, 32'h300C);
    check("t2_hold_instr", ifid_instr, word_at(32'h3008));
    check("t2_hold_pc4", ifid_pc_plus4, 32'h300C);
    check("t2_hold_valid", 32'(ifid_valid), 32'd1);
    next_win();                       // W5
    @(negedge clk);
    check("t2_hold_req2", 32'(imem_req), 32'd0);
    check("t2_hold_pc2", pc, 32'h300C);
    next_win();                       // W6
    stall = 1'b0;
    push(32'h300C, 32'h3010);

    // T3: redirect while the fetch at 0x3010 is waiting.
    next_win();                       // W7
    imem_ack = 1'b0;
    @(negedge clk);
    check("t2_release_pc", pc, 32'h3010);
    next_win();                       // W8
    redirect = 1'b1; seq = 1'b0; src_val = 32'h3400;
    next_win();                       // W9
    redirect = 1'b0;
    @(negedge clk);
    check("t3_addr_a", imem_addr, 32'h3010);
    check("t3_req_a", 32'(imem_req), 32'd1);
    check("t3_valid_a", 32'(ifid_valid), 32'd0);
    next_win();                       // W10
    @(negedge clk);
    check("t3_addr_b", imem_addr, 32'h3010);
    check("t3_valid_b", 32'(ifid_valid), 32'd0);
    next_win();                       // W11
    imem_ack = 1'b1; seq = 1'b1;
    @(negedge clk);
    check("t3_addr_c", imem_addr, 32'h3010);
    next_win();                       // W12
    @(negedge clk);
    check("t3_pc", pc, 32'h3400);
    check("t3_addr_new", imem_addr, 32'h3400);
    check("t3_valid_c", 32'(ifid_valid), 32'd0);
    push(32'h3400, 32'h3404);

    // T4: flush and stall in the same cycle.
    next_win();                       // W13
    stall = 1'b1; flush = 1'b1;
    next_win();                       // W14
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("t4_valid", 32'(ifid_valid), 32'd0);
    check("t4_instr", ifid_instr, NOP);
    check("t4_pc", pc, 32'h3404);
    push(32'h3404, 32'h3408);

    // T5: redirect to the top of memory and wrap.
    next_win();                       // W15
    @(negedge clk);
    check("t4_pc_next", pc, 32'h3408);
    check("t4_valid_next", 32'(ifid_valid), 32'd1);
    redirect = 1'b1; seq = 1'b0; src_val = 32'hFFFF_FFFC;
    next_win();                       // W16
    redirect = 1'b0; seq = 1'b1;
    @(negedge clk);
    check("t5_pc", pc, 32'hFFFF_FFFC);
    check("t5_pc_plus4", pc_plus4, 32'h0000_0000);
    check("t5_valid", 32'(ifid_valid), 32'd0);
    push(32'hFFFF_FFFC, 32'h0000_0000);
    next_win();                       // W17
    @(negedge clk);
    check("t5_wrap_pc", pc, 32'h0000_0000);
    check("t5_wrap_addr", imem_addr, 32'h0000_0000);
    push(32'h0000_0000, 32'h0000_0004);

    // T6: reset while a fetch is outstanding, with a same-cycle ack.
    next_win();                       // W18
    imem_ack = 1'b0;
    @(negedge clk);
    check("t6_pre_pc", pc, 32'h0000_0004);
    next_win();                       // W19
    rst = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    next_win();                       // W20
    rst = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    check("t6_pc", pc, 32'h0000_3000);
    check("t6_valid", 32'(ifid_valid), 32'd0);
    check("t6_req", 32'(imem_req), 32'd1);
    next_win();                       // W21
    imem_ack = 1'b1;
    push(32'h3000, 32'h3004);
    next_win();                       // W22
    imem_ack = 1'b0;
    @(negedge clk);
    check("t6_after_pc", pc, 32'h3004);
    check("t6_after_valid", 32'(ifid_valid), 32'd1);
    next_win(); next_win();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
